// File: rtl/div16_pkg.sv
// Shared constants, state encoding and sign helpers for the 16-bit sequential divider.
package div16_pkg;

    localparam int DIV_W    = 16;
    localparam int DIV_ITER = 16;
    localparam int CNT_W    = $clog2(DIV_ITER);

    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    function automatic logic [DIV_W-1:0] neg16(input logic [DIV_W-1:0] v);
        return ~v + 16'd1;
    endfunction

    // 16'h8000 maps onto itself, which reads correctly as 32768 in the unsigned datapath.
    function automatic logic [DIV_W-1:0] abs16(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? neg16(v) : v;
    endfunction

endpackage

// File: rtl/add16.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with group generate/propagate outputs.
module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        gm,
    output logic        pm
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  pp;
    logic [3:0]  gc;
    logic        cy;

    // NOTE: every variable driven here gets a value on every pass, so no latch is inferred.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pp[k] = &p[4*k +: 4];
        end

        gc[0] = c_in;
        gc[1] = gg[0] | (pp[0] & c_in);
        gc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c_in);
        gc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & c_in);
        gm    = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
              | (pp[3] & pp[2] & pp[1] & gg[0]);
        pm    = &pp;
        c_out = gm | (pm & c_in);

        // Within a group the carry ripples from the lookahead group carry.
        cy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cy = gc[k];
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ cy;
                cy         = g[4*k+j] | (p[4*k+j] & cy);
            end
        end
    end

endmodule

// File: rtl/div16_seq.sv
// Sequential 16-bit restoring divider, one quotient bit per clock via a shared lookahead adder.
// Optional two's-complement operation is enabled by defining DIV16_SIGNED_EN.
module div16_seq
    import div16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_zero
);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] r_reg, q_reg, d_reg;
    logic [DIV_W-1:0] quot_reg, rem_reg;
    logic             dz_reg;

    logic             accept_calc, accept_zero, last_step;
    logic [DIV_W:0]   shifted;
    logic [DIV_W-1:0] trial;
    logic             carry_out, success;
    logic [DIV_W-1:0] r_next, q_next, q_final, r_final;
    logic             unused_gm, unused_pm;

`ifdef DIV16_SIGNED_EN
    logic             neg_q, neg_r;
`endif

    always_comb begin
        next_state  = state;
        accept_calc = 1'b0;
        accept_zero = 1'b0;
        last_step   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        accept_zero = 1'b1;
                        next_state  = ST_DONE;
                    end else begin
                        accept_calc = 1'b1;
                        next_state  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (cnt == '0) begin
                    last_step  = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Trial subtraction R - D as R + ~D + 1; the 17th shifted bit forces success.
    add16 u_trial (
        .a     (shifted[DIV_W-1:0]),
        .b     (~d_reg),
        .c_in  (1'b1),
        .sum   (trial),
        .c_out (carry_out),
        .gm    (unused_gm),
        .pm    (unused_pm)
    );

    always_comb begin
        shifted = {r_reg, q_reg[DIV_W-1]};
        success = shifted[DIV_W] | carry_out;
        r_next  = success ? trial : shifted[DIV_W-1:0];
        q_next  = {q_reg[DIV_W-2:0], success};
`ifdef DIV16_SIGNED_EN
        q_final = neg_q ? neg16(q_next) : q_next;
        r_final = neg_r ? neg16(r_next) : r_next;
`else
        q_final = q_next;
        r_final = r_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            r_reg    <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            quot_reg <= '0;
            rem_reg  <= '0;
            dz_reg   <= 1'b0;
`ifdef DIV16_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            if (accept_calc) begin
                r_reg <= '0;
                cnt   <= CNT_W'(DIV_ITER - 1);
`ifdef DIV16_SIGNED_EN
                q_reg <= abs16(dividend);
                d_reg <= abs16(divisor);
                neg_q <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
                neg_r <= dividend[DIV_W-1];
`else
                q_reg <= dividend;
                d_reg <= divisor;
`endif
            end else if (state == ST_CALC) begin
                r_reg <= r_next;
                q_reg <= q_next;
                if (last_step) begin
                    quot_reg <= q_final;
                    rem_reg  <= r_final;
                    dz_reg   <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end

            if (accept_zero) begin
                quot_reg <= DIV_ZERO_Q;
                rem_reg  <= dividend;
                dz_reg   <= 1'b1;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign quotient  = quot_reg;
    assign remainder = rem_reg;
    assign div_zero  = dz_reg;

endmodule
